// File: rtl/instr_feeder_pkg.sv
// Shared constants and types for the instruction feeder.
// Word layout: [15] halt marker, [8:6] opcode, [5:3] X, [2:0] Y.
package instr_feeder_pkg;

  localparam int HALT_BIT = 15;

  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_MVI = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_IMM,
    ST_WAIT,
    ST_HALT,
    ST_FAULT
  } state_e;

  function automatic logic is_mvi(logic [15:0] w);
    return w[8:6] == OP_MVI;
  endfunction

endpackage

// File: rtl/instr_feeder_prog_ram.sv
// Program store: synchronous write, two combinational read ports
// (current word and the word after it, for mvi immediates).
module instr_feeder_prog_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr0_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [15:0]   rdata0_o,
  output logic [15:0]   rdata1_o
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/instr_feeder.sv
// Feeds program words to the processor over DIN/Run/Done,
// with mvi immediates, halt marker and a Done watchdog.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Load_en,
  input  logic [AW-1:0] Load_addr,
  input  logic [15:0]   Load_data,
  input  logic          Start,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic [AW-1:0] Pc,
  output logic          Busy,
  output logic          Halted,
  output logic          Fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   din_q;
  logic [15:0]   rd0;
  logic [15:0]   rd1;
  logic          we;
  logic          mvi;
  logic          tmo;
  logic          idle_like;
  logic [AW-1:0] pc_nxt;

  assign idle_like = (state_q == ST_IDLE) ||
                     (state_q == ST_HALT) ||
                     (state_q == ST_FAULT);
  assign we     = Load_en && idle_like;
  assign mvi    = is_mvi(rd0);
  assign pc_nxt = pc_q + (mvi ? AW'(2) : AW'(1));
  assign tmo    = cnt_q == CW'(TIMEOUT - 1);

  instr_feeder_prog_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk_i   (Clock),
    .we_i    (we),
    .waddr_i (Load_addr),
    .wdata_i (Load_data),
    .raddr0_i(pc_q),
    .raddr1_i(pc_q + AW'(1)),
    .rdata0_o(rd0),
    .rdata1_o(rd1)
  );

  // Run/DIN decode straight from state so reset drops Run at once
  always_comb begin
    Run = 1'b0;
    DIN = '0;
    unique case (state_q)
      ST_ISSUE: begin
        if (!rd0[HALT_BIT]) begin
          Run = 1'b1;
          DIN = rd0;
        end
      end
      ST_IMM: begin
        Run = 1'b1;
        DIN = rd1;
      end
      ST_WAIT: begin
        Run = 1'b1;
        DIN = din_q;
      end
      default: ;
    endcase
  end

  assign Pc     = pc_q;
  assign Busy   = (state_q == ST_ISSUE) ||
                  (state_q == ST_IMM) ||
                  (state_q == ST_WAIT);
  assign Halted = state_q == ST_HALT;
  assign Fault  = state_q == ST_FAULT;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
    end else begin
      if (state_q == ST_ISSUE || state_q == ST_IMM)
        din_q <= DIN;
      unique case (state_q)
        ST_ISSUE: begin
          if (rd0[HALT_BIT]) begin
            state_q <= ST_HALT;
          end else if (Done) begin
            pc_q  <= pc_nxt;
            cnt_q <= '0;
          end else if (tmo) begin
            state_q <= ST_FAULT;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            state_q <= mvi ? ST_IMM : ST_WAIT;
          end
        end
        ST_IMM, ST_WAIT: begin
          if (Done) begin
            pc_q    <= pc_nxt;
            cnt_q   <= '0;
            state_q <= ST_ISSUE;
          end else if (tmo) begin
            state_q <= ST_FAULT;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            state_q <= ST_WAIT;
          end
        end
        default: begin
          if (Start) begin
            state_q <= ST_ISSUE;
            pc_q    <= '0;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: program flow, mvi, Done delay,
// watchdog, Pc wrap, load gating, restart and async reset.
module tb_instr_feeder;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Load_en;
  logic [3:0]  Load_addr;
  logic [15:0] Load_data;
  logic        Start;
  logic        Done;
  logic [15:0] DIN;
  logic        Run;
  logic [3:0]  Pc;
  logic        Busy;
  logic        Halted;
  logic        Fault;

  int total = 0;
  int bad   = 0;

  instr_feeder dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Load_en  (Load_en),
    .Load_addr(Load_addr),
    .Load_data(Load_data),
    .Start    (Start),
    .Done     (Done),
    .DIN      (DIN),
    .Run      (Run),
    .Pc       (Pc),
    .Busy     (Busy),
    .Halted   (Halted),
    .Fault    (Fault)
  );

  always #5 Clock = ~Clock;

  task automatic load_word(input logic [3:0] a, input logic [15:0] d);
    @(negedge Clock);
    Load_en = 1'b1; Load_addr = a; Load_data = d;
    @(negedge Clock);
    Load_en = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Load_en = 1'b0; Load_addr = '0;
    Load_data = '0; Start = 1'b0; Done = 1'b0;
    #12;
    total++; if (Run !== 1'b0) begin bad++; $display("FAIL rst_run got=%b exp=0", Run); end
    total++; if (DIN !== 16'h0) begin bad++; $display("FAIL rst_din got=%h exp=0000", DIN); end
    total++; if (Pc !== 4'd0) begin bad++; $display("FAIL rst_pc got=%0d exp=0", Pc); end
    total++; if ({Busy, Halted, Fault} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b exp=000", {Busy, Halted, Fault});
    end
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic test_mvi_program();
    load_word(4'd0, 16'h0040);
    load_word(4'd1, 16'h0005);
    load_word(4'd2, 16'h0008);
    load_word(4'd3, 16'h8000);
    start_pulse();
    total++; if (DIN !== 16'h0040 || Run !== 1'b1) begin
      bad++; $display("FAIL p1_issue got=%h/%b exp=0040/1", DIN, Run);
    end
    @(negedge Clock);
    total++; if (DIN !== 16'h0005 || Run !== 1'b1) begin
      bad++; $display("FAIL p1_imm got=%h/%b exp=0005/1", DIN, Run);
    end
    @(negedge Clock);
    total++; if (DIN !== 16'h0005) begin bad++; $display("FAIL p1_wait got=%h exp=0005", DIN); end
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    total++; if (Pc !== 4'd2 || DIN !== 16'h0008) begin
      bad++; $display("FAIL p1_mv got=%0d/%h exp=2/0008", Pc, DIN);
    end
    @(negedge Clock);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    total++; if (Pc !== 4'd3 || Run !== 1'b0) begin
      bad++; $display("FAIL p1_haltword got=%0d/%b exp=3/0", Pc, Run);
    end
    @(negedge Clock);
    total++; if (Halted !== 1'b1 || Pc !== 4'd3 || DIN !== 16'h0) begin
      bad++; $display("FAIL p1_halted got=%b/%0d/%h exp=1/3/0000", Halted, Pc, DIN);
    end
  endtask

  task automatic test_done_delay();
    load_word(4'd0, 16'h0093);
    load_word(4'd1, 16'h8000);
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      total++; if (Run !== 1'b1 || DIN !== 16'h0093) begin
        bad++; $display("FAIL p2_hold%0d got=%b/%h exp=1/0093", i, Run, DIN);
      end
      if (i == 3) Done = 1'b1;
      @(negedge Clock);
    end
    Done = 1'b0;
    total++; if (Pc !== 4'd1) begin bad++; $display("FAIL p2_pc got=%0d exp=1", Pc); end
    @(negedge Clock);
  endtask

  task automatic test_timeout();
    int n;
    start_pulse();
    n = 0;
    while (Fault !== 1'b1 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    total++; if (n !== 15) begin bad++; $display("FAIL p3_cycles got=%0d exp=15", n); end
    total++; if (Run !== 1'b0 || Pc !== 4'd0) begin
      bad++; $display("FAIL p3_frozen got=%b/%0d exp=0/0", Run, Pc);
    end
  endtask

  task automatic test_wrap();
    int n;
    load_word(4'd0, 16'h0048);
    load_word(4'd1, 16'h00AA);
    for (int a = 2; a < 15; a++) load_word(4'(a), 16'h0000);
    load_word(4'd15, 16'h0040);
    Done = 1'b1;
    start_pulse();
    n = 0;
    while (Pc !== 4'd15 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    Done = 1'b0;
    total++; if (Pc !== 4'd15 || DIN !== 16'h0040) begin
      bad++; $display("FAIL p4_reach got=%0d/%h exp=15/0040", Pc, DIN);
    end
    @(negedge Clock);
    total++; if (DIN !== 16'h0048 || Run !== 1'b1) begin
      bad++; $display("FAIL p4_imm got=%h/%b exp=0048/1", DIN, Run);
    end
    @(negedge Clock);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    total++; if (Pc !== 4'd1 || DIN !== 16'h00AA) begin
      bad++; $display("FAIL p4_wrap got=%0d/%h exp=1/00aa", Pc, DIN);
    end
  endtask

  task automatic test_load_busy();
    @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    load_word(4'd0, 16'h0093);
    load_word(4'd1, 16'h8000);
    start_pulse();
    @(negedge Clock);
    Load_en = 1'b1; Load_addr = 4'd1; Load_data = 16'h0000;
    @(negedge Clock);
    Load_en = 1'b0;
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL p5_busy got=%b exp=1", Busy); end
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    total++; if (Run !== 1'b0 || Pc !== 4'd1) begin
      bad++; $display("FAIL p5_kept got=%b/%0d exp=0/1", Run, Pc);
    end
    @(negedge Clock);
    total++; if (Halted !== 1'b1) begin bad++; $display("FAIL p5_halt got=%b exp=1", Halted); end
    Load_en = 1'b1; Load_addr = 4'd0; Load_data = 16'h0008; Start = 1'b1;
    @(negedge Clock);
    Load_en = 1'b0; Start = 1'b0;
    total++; if (Pc !== 4'd0 || DIN !== 16'h0008 || Run !== 1'b1) begin
      bad++; $display("FAIL p5_restart got=%0d/%h/%b exp=0/0008/1", Pc, DIN, Run);
    end
  endtask

  task automatic test_async_reset();
    @(negedge Clock);
    total++; if (Run !== 1'b1 || Busy !== 1'b1) begin
      bad++; $display("FAIL p6_wait got=%b/%b exp=1/1", Run, Busy);
    end
    #2 Resetn = 1'b0;
    #1;
    total++; if (Run !== 1'b0 || Busy !== 1'b0 || Pc !== 4'd0 || DIN !== 16'h0) begin
      bad++; $display("FAIL p6_async got=%b/%b/%0d/%h exp=0/0/0/0000", Run, Busy, Pc, DIN);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    total++; if ({Busy, Halted, Fault} !== 3'b000) begin
      bad++; $display("FAIL p6_idle got=%b exp=000", {Busy, Halted, Fault});
    end
  endtask

  initial begin
    test_reset();
    test_mvi_program();
    test_done_delay();
    test_timeout();
    test_wrap();
    test_load_busy();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
